imem_loader: RTL

//  Byte-stream writer for the instruction memory read by the fetch stage.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_byte_packer.sv | 34 +++
 rtl/imem_loader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR_HI = 3'd1,
        ST_HDR_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam int unsigned WORD_BYTES = 4;

    function automatic logic takes_bytes(input state_e s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA);
    endfunction

    function automatic logic is_busy(input state_e s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_DATA) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian 4-byte packer: first accepted byte ends up in word[31:24].
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        shift_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;

    // Shift register and byte counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= 32'd0;
            cnt_q  <= 2'd0;
        end else if (clear_i) begin
            word_q <= 32'd0;
            cnt_q  <= 2'd0;
        end else if (shift_en_i) begin
            word_q <= {word_q[23:0], byte_i};
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    assign word_o = word_q;
    assign full_o = shift_en_i && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the core in reset until loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  core_rst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    localparam logic [31:0] CAP_WORDS = 32'd1 << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic                  byte_ready_q, mem_we_q, core_rst_q, busy_q, done_q, error_q;
    logic                  accept_s, clear_s, shift_s, full_s, last_s;
    logic [15:0]           hdr_count_s;

    assign accept_s    = byte_valid_i && byte_ready_q;
    assign hdr_count_s = {count_q[15:8], byte_i};
    // 32-bit compare so a full-capacity load never wraps the index check
    assign last_s      = (32'(idx_q) == (32'(count_q) - 32'd1));

    byte_packer u_packer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_s),
        .shift_en_i (shift_s),
        .byte_i     (byte_i),
        .word_o     (mem_wdata_o),
        .full_o     (full_s)
    );

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        clear_s = 1'b0;
        shift_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d = ST_HDR_HI;
                    count_d = 16'd0;
                    idx_d   = '0;
                    clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HDR_HI: begin
                if (accept_s) begin
                    count_d[15:8] = byte_i;
                    state_d       = ST_HDR_LO;
                end else begin
                    state_d = state_q;
                end
            end
            ST_HDR_LO: begin
                if (accept_s) begin
                    count_d = hdr_count_s;
                    if (hdr_count_s == 16'd0) begin
                        state_d = ST_DONE;
                    end else if (32'(hdr_count_s) > CAP_WORDS) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_DATA: begin
                shift_s = accept_s;
                if (full_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_WRITE: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_DATA;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters and registered outputs derived from the next state
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            count_q      <= 16'd0;
            idx_q        <= '0;
            mem_addr_q   <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            core_rst_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            idx_q        <= idx_d;
            byte_ready_q <= takes_bytes(state_d);
            mem_we_q     <= (state_d == ST_WRITE);
            core_rst_q   <= (state_d != ST_DONE);
            busy_q       <= is_busy(state_d);
            done_q       <= (state_d == ST_DONE);
            error_q      <= (state_d == ST_ERR);
            if (state_d == ST_WRITE) begin
                mem_addr_q <= idx_q;
            end
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign core_rst_o   = core_rst_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;

endmodule
